// File: rtl/mem_pkg.sv
// Shared types for the data_mem_sync slice: access size encodings, the
// controller FSM states, the captured request payload and a size helper.
package mem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_e;

  // Request fields captured at accept; held stable for the whole access.
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    size_e       size;
    logic        sgn;
    logic [31:0] wdata;
  } req_t;

  // Number of bytes touched by an access; 0 marks the reserved encoding.
  function automatic logic [2:0] size_bytes(input size_e size);
    case (size)
      SZ_BYTE: size_bytes = 3'd1;
      SZ_HALF: size_bytes = 3'd2;
      SZ_WORD: size_bytes = 3'd4;
      default: size_bytes = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_fmt.sv
// Byte-lane formatter for the big-endian data memory.
// Lane i is the byte at (aligned word base + i); lane 0 is the MSB of rword.
//   rword   : the four bytes of the aligned word holding the access
//   size    : access size
//   offset  : address bits [1:0]
//   sgn     : sign-extend byte/half reads
//   wdata   : right-justified write data
//   rdata_c : extended read data
//   wen_c   : per-lane write enables
//   wbyte_c : per-lane write bytes
module mem_lane_fmt
  import mem_pkg::*;
(
  input  logic [31:0]     rword,
  input  size_e           size,
  input  logic [1:0]      offset,
  input  logic            sgn,
  input  logic [31:0]     wdata,
  output logic [31:0]     rdata_c,
  output logic [3:0]      wen_c,
  output logic [3:0][7:0] wbyte_c
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  // Read lane selection and extension.
  always_comb begin
    rdata_c = '0;
    case (offset)
      2'd0:    rbyte = rword[31:24];
      2'd1:    rbyte = rword[23:16];
      2'd2:    rbyte = rword[15:8];
      default: rbyte = rword[7:0];
    endcase
    rhalf = offset[1] ? rword[15:0] : rword[31:16];
    case (size)
      SZ_BYTE: rdata_c = {{24{sgn & rbyte[7]}}, rbyte};
      SZ_HALF: rdata_c = {{16{sgn & rhalf[15]}}, rhalf};
      SZ_WORD: rdata_c = rword;
      default: rdata_c = '0;
    endcase
  end

  // Write lane steering: the most significant data byte lands at the lowest address.
  always_comb begin
    wen_c   = '0;
    wbyte_c = '0;
    case (size)
      SZ_BYTE: begin
        wen_c[offset] = 1'b1;
        wbyte_c       = {4{wdata[7:0]}};
      end
      SZ_HALF: begin
        wen_c   = offset[1] ? 4'b1100 : 4'b0011;
        wbyte_c = {wdata[7:0], wdata[15:8], wdata[7:0], wdata[15:8]};
      end
      SZ_WORD: begin
        wen_c   = 4'b1111;
        wbyte_c = {wdata[7:0], wdata[15:8], wdata[23:16], wdata[31:24]};
      end
      default: begin
        wen_c   = '0;
        wbyte_c = '0;
      end
    endcase
  end

endmodule

// File: rtl/data_mem_sync.sv
// Clocked byte-addressed big-endian data memory with valid/ready request,
// programmable wait states and a one-cycle response pulse.
//   clk, rst_n          : clock, async active-low reset
//   req_valid/req_ready : request handshake
//   req_we, req_addr, req_size, req_signed, req_wdata : request payload
//   rsp_valid           : one-cycle response pulse
//   rsp_rdata, rsp_err  : read data (0 on writes/errors) and error flag
module data_mem_sync
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_STATES = 0,
  parameter string       INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_LOAD =
    (WAIT_STATES > 0) ? CNT_W'(WAIT_STATES - 1) : '0;

  logic [7:0] mem [DEPTH];

  state_e          state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic            accept_c, fire_c;
  req_t            req_q;

  logic [AW-1:0]   base;
  logic [31:0]     rword;
  logic [32:0]     end_c;
  logic            err_c;
  logic [31:0]     rdata_c;
  logic [3:0]      wen_c;
  logic [3:0][7:0] wbyte_c;

  // Next-state logic; fire_c marks the cycle whose closing edge commits the access.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept_c  = 1'b0;
    fire_c    = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          accept_c  = 1'b1;
          cnt_nxt   = CNT_LOAD;
          state_nxt = (WAIT_STATES > 0) ? WAIT : RESP;
        end
      end
      WAIT: begin
        if (cnt == '0) state_nxt = RESP;
        else           cnt_nxt   = cnt - 4'd1;
      end
      RESP: begin
        fire_c    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM state, wait counter and request capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      req_ready <= 1'b1;
      req_q     <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      req_ready <= (state_nxt == IDLE);
      if (accept_c) begin
        req_q.we    <= req_we;
        req_q.addr  <= req_addr;
        req_q.size  <= size_e'(req_size);
        req_q.sgn   <= req_signed;
        req_q.wdata <= req_wdata;
      end
    end
  end

  // Full 33-bit end address so high address bits can never alias into range.
  assign end_c = 33'(req_q.addr) + 33'(size_bytes(req_q.size));
  assign err_c = (req_q.size == SZ_RSVD)
               | ((req_q.size == SZ_HALF) & req_q.addr[0])
               | ((req_q.size == SZ_WORD) & (req_q.addr[1:0] != 2'b00))
               | (end_c > 33'(DEPTH));

  // Aligned accesses never cross a word, so the aligned word covers every lane.
  assign base  = {req_q.addr[AW-1:2], 2'b00};
  assign rword = {mem[base], mem[base | AW'(1)], mem[base | AW'(2)], mem[base | AW'(3)]};

  mem_lane_fmt u_lane_fmt (
    .rword   (rword),
    .size    (req_q.size),
    .offset  (req_q.addr[1:0]),
    .sgn     (req_q.sgn),
    .wdata   (req_q.wdata),
    .rdata_c (rdata_c),
    .wen_c   (wen_c),
    .wbyte_c (wbyte_c)
  );

  // Storage array: not reset, written only on a clean write leaving RESP.
  always_ff @(posedge clk) begin
    if (fire_c && req_q.we && !err_c) begin
      for (int i = 0; i < 4; i++) begin
        if (wen_c[i]) mem[base | AW'(i)] <= wbyte_c[i];
      end
    end
  end

  // Response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= fire_c;
      if (fire_c) begin
        rsp_err   <= err_c;
        rsp_rdata <= (req_q.we || err_c) ? '0 : rdata_c;
      end
    end
  end

endmodule
